// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// state encoding and default widths.
package muldiv_pkg;

  localparam int MD_W     = 32;
  localparam int MD_CNT_W = $clog2(MD_W);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // An explicit compare (not the borrow bit) keeps divide-by-zero well behaved:
  // every step then succeeds, leaving quotient all ones and remainder = dividend.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (shifted >= {1'b0, divisor}) begin
      rem_nxt = diff[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit holding HI/LO.
// Define FAST_MULT_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int W = MD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(W);

  state_e state, state_nxt;

  logic [2*W-1:0] acc;
  logic [W-1:0]   divisor_q;
  logic [CW-1:0]  cnt;
  logic           is_div_q;
  logic           neg_res;
  logic           neg_rem;
  logic           div_zero;
  logic [W-1:0]   hi_q, lo_q;

  op_e          op_c;
  logic         accept, is_mul, is_div, sgn;
  logic [W-1:0] a_abs, b_abs;
  logic [W:0]   mul_sum;
  logic [W-1:0] div_rem, div_quo;
  logic [W-1:0] fix_hi, fix_lo;
  logic [2*W-1:0] prod_neg;

  // A new op is taken in IDLE and also in FIX, whose cycle already has busy low.
  always_comb begin
    op_c   = op_e'(op);
    accept = start && (state == ST_IDLE || state == ST_FIX);
    is_mul = (op_c == OP_MULT) || (op_c == OP_MULTU);
    is_div = (op_c == OP_DIV) || (op_c == OP_DIVU);
    sgn    = is_signed_op(op_c);
    a_abs  = (sgn && rs_val[W-1]) ? -rs_val : rs_val;
    b_abs  = (sgn && rt_val[W-1]) ? -rt_val : rt_val;
  end

  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, divisor_q} : {(W+1){1'b0}});
  end

  div_step #(.W(W)) u_div_step (
    .rem     (acc[2*W-1:W]),
    .quo     (acc[W-1:0]),
    .divisor (divisor_q),
    .rem_nxt (div_rem),
    .quo_nxt (div_quo)
  );

  // Sign correction of the unsigned magnitude result held in acc.
  always_comb begin
    prod_neg = -acc;
    if (!is_div_q) begin
      {fix_hi, fix_lo} = neg_res ? prod_neg : acc;
    end else begin
      fix_hi = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
      if (div_zero)     fix_lo = {W{1'b1}};
      else if (neg_res) fix_lo = -acc[W-1:0];
      else              fix_lo = acc[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_FIX: begin
        state_nxt = ST_IDLE;
        if (accept && is_mul) begin
`ifdef FAST_MULT_EN
          state_nxt = ST_FIX;
`else
          state_nxt = ST_MUL;
`endif
        end else if (accept && is_div) begin
          state_nxt = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (cnt == '0) state_nxt = ST_FIX;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_MUL) || (state == ST_DIV);
    done = (state == ST_FIX);
    hi   = done ? fix_hi : hi_q;
    lo   = done ? fix_lo : lo_q;
  end

  // NOTE: the datapath registers carry no reset; they are always loaded at
  // accept before anything reads them, and only state and hi/lo need a value.
  always_ff @(posedge clk) begin
    if (accept && (is_mul || is_div)) begin
      is_div_q  <= is_div;
      divisor_q <= b_abs;
      cnt       <= CW'(W - 1);
      neg_res   <= sgn && (rs_val[W-1] ^ rt_val[W-1]);
      neg_rem   <= sgn && rs_val[W-1];
      div_zero  <= is_div && (rt_val == '0);
`ifdef FAST_MULT_EN
      acc <= is_mul ? ({{W{1'b0}}, a_abs} * {{W{1'b0}}, b_abs}) : {{W{1'b0}}, a_abs};
`else
      acc <= {{W{1'b0}}, a_abs};
`endif
    end else if (state == ST_MUL) begin
      acc <= {mul_sum, acc[W-1:1]};
      cnt <= cnt - 1'b1;
    end else if (state == ST_DIV) begin
      acc <= {div_rem, div_quo};
      cnt <= cnt - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the later MTHI/MTLO write overrides the FIX write.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (state == ST_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
      if (accept && op_c == OP_MTHI) hi_q <= rs_val;
      if (accept && op_c == OP_MTLO) lo_q <= rs_val;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  rs_val, rt_val;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] m_hi, m_lo;

  muldiv_unit #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one cycle (cycle 0); returns in cycle 1 with junk operands.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
    op     = 3'd6;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o);
`ifdef FAST_MULT_EN
    if (o < 3'd2) return 1;
`endif
    return o < 3'd4 ? 33 : 0;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    int si, sj;
    sa = $signed(a);
    sb = $signed(b);
    si = a;
    sj = b;
    case (o)
      3'd0: return sa * sb;
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(si % sj), 32'(si / sj)};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int lat;
    issue(o, a, b);
    wait_done(lat);
    check({name, " latency"}, 64'(lat), 64'(exp_lat(o)));
    check({name, " busy"}, {63'b0, busy}, 64'h0);
    check({name, " hi"}, {32'b0, hi}, {32'b0, eh});
    check({name, " lo"}, {32'b0, lo}, {32'b0, el});
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    int bad;
    int lat;
    logic [63:0] r;
    logic [2:0] o;
    logic [31:0] a, b;

    vt[0]  = '{3'd0, 32'd7,          32'd6,          32'h0,          32'h0000_002A};
    vt[1]  = '{3'd0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vt[2]  = '{3'd1, 32'hFFFF_FFFF,  32'd1,          32'h0,          32'hFFFF_FFFF};
    vt[3]  = '{3'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD};
    vt[4]  = '{3'd3, 32'd7,          32'd0,          32'h0000_0007,  32'hFFFF_FFFF};
    vt[5]  = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000};
    vt[6]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001};
    vt[7]  = '{3'd2, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001,  32'hFFFF_FFFD};
    vt[8]  = '{3'd2, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFFF};
    vt[9]  = '{3'd0, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'h0};
    vt[10] = '{3'd3, 32'hFFFF_FFFF,  32'h10,         32'h0000_000F,  32'h0FFF_FFFF};

    rst = 1'b1; start = 1'b0; op = 3'd6; rs_val = '0; rt_val = '0;
    tick(); tick();
    check("reset busy", {63'b0, busy}, 64'h0);
    check("reset done", {63'b0, done}, 64'h0);
    check("reset hi/lo", {hi, lo}, 64'h0);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;

    // MULT 7 x 6: busy window then result.
    issue(3'd0, 32'd7, 32'd6);
`ifdef FAST_MULT_EN
    check("fast mult busy", {63'b0, busy}, 64'h0);
    check("fast mult done", {63'b0, done}, 64'h1);
    check("fast mult lo", {32'b0, lo}, 64'h2A);
`else
    bad = 0;
    for (int c = 1; c <= 32; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      tick();
    end
    check("mult busy cycles 1-32", 64'(bad), 64'h0);
    check("mult done cycle 33", {63'b0, done}, 64'h1);
    check("mult 7x6", {hi, lo}, 64'h2A);
`endif
    tick();
    check("done is a pulse", {63'b0, done}, 64'h0);
    check("hi/lo hold after done", {hi, lo}, 64'h2A);

    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].exp_hi, vt[i].exp_lo);
    tick();

    // MTLO/MTHI, then MTLO issued mid-divide must be ignored.
    issue(3'd5, 32'h55, 32'h0);
    issue(3'd4, 32'h1234, 32'h0);
    check("mthi hi/lo", {hi, lo}, {32'h1234, 32'h55});
    check("mthi done", {63'b0, done}, 64'h0);
    check("mthi busy", {63'b0, busy}, 64'h0);
    issue(3'd2, 32'd100, 32'd7);
    tick(); tick(); tick();
    issue(3'd5, 32'hDEAD_BEEF, 32'h0);
    check("mtlo while busy ignored", {32'b0, lo}, 64'h55);
    wait_done(lat);
    check("div after ignored mtlo", {hi, lo}, {32'd2, 32'd14});
    tick();
    check("div result holds", {hi, lo}, {32'd2, 32'd14});

    // NOP start is ignored.
    issue(3'd6, 32'hAAAA_AAAA, 32'h1);
    check("nop busy/done", {62'b0, busy, done}, 64'h0);
    check("nop hi/lo", {hi, lo}, {32'd2, 32'd14});

    // Reset mid-divide aborts with no result.
    issue(3'd3, 32'd100, 32'd7);
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {63'b0, busy}, 64'h0);
    check("abort hi/lo", {hi, lo}, 64'h0);
    bad = 0;
    for (int c = 0; c < 36; c++) begin
      if (done !== 1'b0) bad++;
      tick();
    end
    check("abort no done", 64'(bad), 64'h0);
    m_hi = '0; m_lo = '0;
    run_op("multu after abort", 3'd1, 32'd3, 32'd5, 32'h0, 32'd15);

    // Randomized ops against the arithmetic model; results back-to-back.
    for (int n = 0; n < 60; n++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        2: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (o >= 3'd4) begin
        issue(o, a, b);
        if (o == 3'd4) m_hi = a;
        else           m_lo = a;
        check($sformatf("rand%0d mt hi/lo", n), {hi, lo}, {m_hi, m_lo});
      end else begin
        r = model(o, a, b);
        run_op($sformatf("rand%0d op%0d %h %h", n, o, a, b), o, a, b, r[63:32], r[31:0]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
